// File: rtl/mem_io_responder.sv
// -----------------------------------------------------------------------------
// mem_io_responder
//   Memory-side responder for the SLC datapath memory port. A request is
//   accepted from IDLE, held for WAIT_STATES extra cycles, then committed to
//   the on-chip RAM or the memory-mapped I/O word. Completion is signalled by
//   a single-cycle Mem_R strobe.
//
// Handshake: Mem_Req is a level held by the CPU until it sees Mem_R. The
//   request is accepted on the first rising edge in IDLE with Mem_Req=1. At
//   that edge Mem_WE, Mem_Addr and Mem_WData are captured, and later changes
//   on them are ignored. Mem_R is high for exactly one cycle per request. A
//   request still held after Mem_R parks the FSM in HOLD until Mem_Req drops,
//   so one held level never produces a second access.
//
// Ports:
//   Clk        in   system clock, rising edge
//   Reset_n    in   asynchronous active-low reset
//   Mem_Req    in   request level
//   Mem_WE     in   1 = write, 0 = read
//   Mem_Addr   in   [15:0] address (MAR)
//   Mem_WData  in   [15:0] write data (MDR)
//   Switches   in   [15:0] source for I/O reads
//   Mem_RData  out  [15:0] registered read data (to MDR_In)
//   Mem_R      out  completion strobe
//   Busy       out  high whenever the FSM is not in IDLE
//   Addr_Err   out  high with Mem_R when the address hit neither RAM nor I/O
//   Hex_Disp   out  [15:0] I/O write register driving the hex display
//   Dbg_State  out  [1:0] current FSM state, for checkers
// -----------------------------------------------------------------------------
module mem_io_responder #(
  parameter int unsigned WAIT_STATES = 2,
  parameter int unsigned DEPTH       = 1024,
  parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Mem_Req,
  input  logic        Mem_WE,
  input  logic [15:0] Mem_Addr,
  input  logic [15:0] Mem_WData,
  input  logic [15:0] Switches,
  output logic [15:0] Mem_RData,
  output logic        Mem_R,
  output logic        Busy,
  output logic        Addr_Err,
  output logic [15:0] Hex_Disp,
  output logic [1:0]  Dbg_State
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [3:0]  CNT_INIT = 4'(WAIT_STATES);
  // One extra bit so that DEPTH=65536 still compares correctly.
  localparam logic [16:0] DEPTH_L  = 17'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2,
    S_HOLD   = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic [15:0] hex_q, hex_d;
  logic        err_q, err_d;
  logic        ram_we;

  logic [15:0] ram_q [DEPTH];

  logic          hit_io;
  logic          hit_ram;
  logic [AW-1:0] ram_idx;

  // Decode from the captured address, so input changes after acceptance
  // have no effect. I/O wins over RAM.
  assign hit_io  = (addr_q == IO_ADDR);
  assign hit_ram = ({1'b0, addr_q} < DEPTH_L);
  assign ram_idx = addr_q[AW-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    hex_d   = hex_q;
    err_d   = err_q;
    ram_we  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (Mem_Req) begin
          we_d    = Mem_WE;
          addr_d  = Mem_Addr;
          wdata_d = Mem_WData;
          cnt_d   = CNT_INIT;
          err_d   = 1'b0;
          state_d = S_ACCESS;
        end
      end

      S_ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // Commit edge: the access happens here, not at acceptance, so a
          // reset during the wait leaves RAM and I/O untouched.
          state_d = S_DONE;
          if (hit_io) begin
            if (we_q) hex_d   = wdata_q;
            else      rdata_d = Switches;
          end else if (hit_ram) begin
            if (we_q) ram_we  = 1'b1;
            else      rdata_d = ram_q[ram_idx];
          end else begin
            err_d = 1'b1;
            if (!we_q) rdata_d = 16'h0000;
          end
        end
      end

      S_DONE: begin
        state_d = Mem_Req ? S_HOLD : S_IDLE;
      end

      S_HOLD: begin
        if (!Mem_Req) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      rdata_q <= 16'h0000;
      hex_q   <= 16'h0000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      hex_q   <= hex_d;
      err_q   <= err_d;
    end
  end

  // RAM contents survive reset. ram_we derives from state_q, which reset
  // forces to IDLE, so an aborted write never reaches the array.
  always_ff @(posedge Clk) begin
    if (ram_we) ram_q[ram_idx] <= wdata_q;
  end

  assign Mem_R     = (state_q == S_DONE);
  assign Busy      = (state_q != S_IDLE);
  assign Addr_Err  = (state_q == S_DONE) && err_q;
  assign Mem_RData = rdata_q;
  assign Hex_Disp  = hex_q;
  assign Dbg_State = state_q;

endmodule
